// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: FSM state encoding and master ids.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One master's word-access port: req/ack handshake plus command and read data.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 6
);
    logic                  req;
    logic                  we;
    logic [BUS_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, output we, output addr, output wdata, input ack, input rdata);
    modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the master that was not served last wins.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       id
);

    always_comb begin
        valid = |req;
        id    = M0;
        case (req)
            2'b11:   id = ~last;
            2'b10:   id = M1;
            default: id = M0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and sequencer for the single-port data RAM.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         m0,
    dmem_arbiter_if.slave         m1,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [BUS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  gnt_id
);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [BUS_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  pick_valid;
    logic                  pick_id;

    rr_pick2 u_pick (
        .req   ({m1.req, m0.req}),
        .last  (last_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = pick_id;
                    we_d    = (pick_id == M1) ? m1.we    : m0.we;
                    addr_d  = (pick_id == M1) ? m1.addr  : m0.addr;
                    wdata_d = (pick_id == M1) ? m1.wdata : m0.wdata;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // A write leaves zero behind so the ack never carries stale read data.
                rdata_d = we_q ? '0 : mem_rdata;
                state_d = StDone;
            end
            StDone: begin
                last_d  = gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= M1;
            gnt_q   <= M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset overrides an in-flight access so an aborted write never reaches the RAM.
    assign mem_re    = (state_q == StAccess) && !we_q && !rst;
    assign mem_we    = (state_q == StAccess) &&  we_q && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);
    assign gnt_id    = gnt_q;

    assign m0.ack   = (state_q == StDone) && (gnt_q == M0);
    assign m1.ack   = (state_q == StDone) && (gnt_q == M1);
    assign m0.rdata = m0.ack ? rdata_q : '0;
    assign m1.rdata = m1.ack ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM behind it.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 6;

    logic          clk;
    logic          rst;
    logic          mem_re;
    logic          mem_we;
    logic [BW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          gnt_id;
    logic [DW-1:0] ram [64];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) m0_bus ();
    dmem_arbiter_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) m1_bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    assign mem_rdata = mem_re ? ram[mem_addr] : '0;
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic id, input logic req, input logic we,
                         input logic [BW-1:0] addr, input logic [DW-1:0] wdata);
        if (id) begin
            m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
        end else begin
            m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
        end
    endtask

    function automatic logic ack_of(input logic id);
        return id ? m1_bus.ack : m0_bus.ack;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input logic id);
        return id ? m1_bus.rdata : m0_bus.rdata;
    endfunction

    // Single uncontended access starting from an IDLE negedge; ends back in IDLE.
    task automatic service(input logic id, input logic we, input logic [BW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                           input string tag);
        set_m(id, 1'b1, we, addr, wdata);
        step();
        chk({tag, "_acc_busy"}, busy, 1);
        chk({tag, "_acc_gnt"}, gnt_id, id);
        chk({tag, "_acc_we"}, mem_we, we);
        chk({tag, "_acc_re"}, mem_re, !we);
        chk({tag, "_acc_addr"}, mem_addr, addr);
        if (we) chk({tag, "_acc_wdata"}, mem_wdata, wdata);
        chk({tag, "_acc_noack"}, ack_of(id), 0);
        step();
        chk({tag, "_done_ack"}, ack_of(id), 1);
        chk({tag, "_done_rdata"}, rdata_of(id), exp_rd);
        chk({tag, "_done_other_ack"}, ack_of(!id), 0);
        chk({tag, "_done_other_rdata"}, rdata_of(!id), 0);
        chk({tag, "_done_mem_idle"}, {mem_re, mem_we}, 0);
        set_m(id, 1'b0, we, addr, wdata);
        step();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ack"}, ack_of(id), 0);
    endtask

    initial begin
        rst = 1'b1;
        set_m(1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        repeat (3) step();

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {m1_bus.ack, m0_bus.ack}, 0);
        chk("rst_rdatas", {m1_bus.rdata, m0_bus.rdata}, 0);
        rst = 1'b0;

        // m0 write then m1 read-back of the same word.
        service(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 32'h0, "t1");
        service(1'b1, 1'b0, 6'd5, 32'h0, 32'hDEADBEEF, "t2");

        // Simultaneous requests straight after reset: m0 first, then m1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_m(1'b0, 1'b1, 1'b1, 6'd1, 32'h11);
        set_m(1'b1, 1'b1, 1'b1, 6'd2, 32'h22);
        step();
        chk("t3_first_gnt", gnt_id, 0);
        chk("t3_first_addr", mem_addr, 1);
        chk("t3_first_we", mem_we, 1);
        step();
        chk("t3_m0_ack", m0_bus.ack, 1);
        chk("t3_m1_wait", m1_bus.ack, 0);
        set_m(1'b0, 1'b0, 1'b1, 6'd1, 32'h11);
        step();
        chk("t3_gap_busy", busy, 0);
        step();
        chk("t3_second_gnt", gnt_id, 1);
        chk("t3_second_addr", mem_addr, 2);
        chk("t3_second_wdata", mem_wdata, 32'h22);
        step();
        chk("t3_m1_ack", m1_bus.ack, 1);
        chk("t3_m0_quiet", m0_bus.ack, 0);
        set_m(1'b1, 1'b0, 1'b1, 6'd2, 32'h22);
        step();

        // Both requesting continuously for six services.
        set_m(1'b0, 1'b1, 1'b0, 6'd1, '0);
        set_m(1'b1, 1'b1, 1'b0, 6'd2, '0);
        for (int i = 0; i < 6; i++) begin
            logic exp_id;
            exp_id = logic'(i % 2);
            step();
            chk($sformatf("t4_gnt%0d", i), gnt_id, exp_id);
            chk($sformatf("t4_re%0d", i), {mem_re, mem_we}, 2'b10);
            step();
            chk($sformatf("t4_ack%0d", i), {m1_bus.ack, m0_bus.ack}, exp_id ? 2'b10 : 2'b01);
            chk($sformatf("t4_rd%0d", i), rdata_of(exp_id), exp_id ? 32'h22 : 32'h11);
            chk($sformatf("t4_done_mem%0d", i), {mem_re, mem_we}, 0);
            if (i == 5) begin
                set_m(1'b0, 1'b0, 1'b0, 6'd1, '0);
                set_m(1'b1, 1'b0, 1'b0, 6'd2, '0);
            end
            step();
            chk($sformatf("t4_idle%0d", i), {busy, mem_re, mem_we}, 0);
        end

        // Reset during an m1 write must abort it without touching the RAM.
        service(1'b0, 1'b1, 6'd9, 32'h99, 32'h0, "t5pre");
        set_m(1'b1, 1'b1, 1'b1, 6'd9, 32'h00000BAD);
        step();
        chk("t5_acc_gnt", gnt_id, 1);
        rst = 1'b1;
        #1;
        chk("t5_we_suppressed", mem_we, 0);
        set_m(1'b1, 1'b0, 1'b1, 6'd9, 32'h00000BAD);
        step();
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_noack", m1_bus.ack, 0);
        rst = 1'b0;
        step();
        chk("t5_post_noack", m1_bus.ack, 0);
        service(1'b0, 1'b0, 6'd9, 32'h0, 32'h99, "t5rd");

        // m0 command changes while m1 is served; only the IDLE-sampled value counts.
        service(1'b0, 1'b1, 6'd7, 32'h77, 32'h0, "t6pre");
        set_m(1'b1, 1'b1, 1'b0, 6'd9, '0);
        step();
        chk("t6_m1_gnt", gnt_id, 1);
        chk("t6_m1_addr", mem_addr, 9);
        set_m(1'b0, 1'b1, 1'b0, 6'd3, '0);
        step();
        chk("t6_m1_ack", m1_bus.ack, 1);
        chk("t6_m1_rdata", m1_bus.rdata, 32'h99);
        chk("t6_addr_held", mem_addr, 9);
        chk("t6_m0_noack", m0_bus.ack, 0);
        set_m(1'b0, 1'b1, 1'b0, 6'd7, '0);
        set_m(1'b1, 1'b0, 1'b0, 6'd9, '0);
        step();
        chk("t6_idle_busy", busy, 0);
        step();
        chk("t6_m0_gnt", gnt_id, 0);
        chk("t6_m0_addr", mem_addr, 7);
        chk("t6_m0_re", {mem_re, mem_we}, 2'b10);
        step();
        chk("t6_m0_ack", m0_bus.ack, 1);
        chk("t6_m0_rdata", m0_bus.rdata, 32'h77);
        set_m(1'b0, 1'b0, 1'b0, 6'd7, '0);
        step();
        chk("t6_end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
